// File: rtl/execute_mdu.sv
// execute_mdu: iterative multiply/divide unit for the execute stage.
// Multiplies by shift-add and divides by restoring division, one bit per cycle,
// over 32 iterations for W variants and XLEN iterations otherwise.
// Define MDU_DIV_EN to build the divider in; without it, func 4-7 complete in
// one cycle with a zero result and mdu_o_illegal raised.
module execute_mdu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mdu_i_valid,
  output logic            mdu_o_ready,
  input  logic [2:0]      mdu_i_func,
  input  logic            mdu_i_W_instr,
  input  logic [XLEN-1:0] mdu_i_valA,
  input  logic [XLEN-1:0] mdu_i_valB,
  input  logic            mdu_i_flush,
  output logic            mdu_o_valid,
  input  logic            mdu_i_ready,
  output logic [XLEN-1:0] mdu_o_valE,
  output logic            mdu_o_illegal
);

  localparam int CW = 7;
  localparam logic [XLEN-1:0] MASK32 = XLEN'(64'h0000_0000_FFFF_FFFF);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_next;

  // Sign-extend a 32-bit W result to the full datapath width
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Magnitude of an operand, kept within 32 bits for W operations
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg, input logic w);
    logic [XLEN-1:0] m;
    m = neg ? (~v + XLEN'(1)) : v;
    return w ? (m & MASK32) : m;
  endfunction

  logic            w_in, sign_a_in, sign_b_in, is_div_in, accept, last;
  logic            mul_neg_a, mul_neg_b, short_op, illegal_in;
  logic [XLEN-1:0] a_in, b_in, short_res, div_res, mul_res;

  // W is only meaningful on a 64-bit datapath
  assign w_in      = (XLEN == 64) && mdu_i_W_instr;
  assign a_in      = w_in ? (mdu_i_valA & MASK32) : mdu_i_valA;
  assign b_in      = w_in ? (mdu_i_valB & MASK32) : mdu_i_valB;
  assign sign_a_in = w_in ? mdu_i_valA[31] : mdu_i_valA[XLEN-1];
  assign sign_b_in = w_in ? mdu_i_valB[31] : mdu_i_valB[XLEN-1];
  assign is_div_in = mdu_i_func[2];
  assign accept    = mdu_i_valid && mdu_o_ready && !mdu_i_flush;
  assign mul_neg_a = sign_a_in && ((mdu_i_func == 3'd1) || (mdu_i_func == 3'd2));
  assign mul_neg_b = sign_b_in && (mdu_i_func == 3'd1);

  logic [2:0]        func_q;
  logic              w_q, mul_neg_q, illegal_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] mcand, prod, prod_next, prod_fix;
  logic [XLEN-1:0]   mplier, val_e;

  assign last = (cnt == (w_q ? CW'(31) : CW'(XLEN-1)));

  // Multiplier step and result selection for the final iteration
  always_comb begin
    prod_next = prod + (mplier[0] ? mcand : '0);
    prod_fix  = mul_neg_q ? -prod_next : prod_next;
    mul_res   = '0;
    if (func_q == 3'd0)
      mul_res = w_q ? sext32(prod_fix[31:0]) : prod_fix[XLEN-1:0];
    else
      mul_res = w_q ? sext32(prod_fix[63:32]) : prod_fix[2*XLEN-1:XLEN];
  end

`ifdef MDU_DIV_EN
  logic              div_signed, div_neg_a, div_neg_b, div_zero, div_ovf;
  logic              quo_neg_q, rem_neg_q, bit_in, ge;
  logic [XLEN-1:0]   min_in, ones_in, a_fix, dvd, sor, rem, quo;
  logic [XLEN-1:0]   rem_next, quo_next, q_fix, r_fix, d_sel;
  logic [XLEN:0]     rem_sh, rem_diff;

  assign div_signed = ~mdu_i_func[0];
  assign div_neg_a  = div_signed && sign_a_in;
  assign div_neg_b  = div_signed && sign_b_in;
  assign min_in     = w_in ? XLEN'(64'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
  assign ones_in    = w_in ? MASK32 : '1;
  assign a_fix      = w_in ? sext32(mdu_i_valA[31:0]) : mdu_i_valA;
  assign div_zero   = (b_in == '0);
  assign div_ovf    = div_signed && (a_in == min_in) && (b_in == ones_in);
  assign short_op   = is_div_in && (div_zero || div_ovf);
  assign illegal_in = 1'b0;

  // Zero-divisor and overflow results are known at acceptance
  always_comb begin
    short_res = '0;
    if (div_zero)
      short_res = mdu_i_func[1] ? a_fix : '1;
    else if (div_ovf)
      short_res = mdu_i_func[1] ? '0 : a_fix;
  end

  // Restoring division step plus sign correction for the final iteration
  always_comb begin
    bit_in   = w_q ? dvd[31] : dvd[XLEN-1];
    rem_sh   = {rem, bit_in};
    rem_diff = rem_sh - {1'b0, sor};
    ge       = ~rem_diff[XLEN];
    rem_next = ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_next = (quo << 1) | XLEN'(ge);
    q_fix    = quo_neg_q ? -quo_next : quo_next;
    r_fix    = rem_neg_q ? -rem_next : rem_next;
    d_sel    = func_q[1] ? r_fix : q_fix;
    div_res  = w_q ? sext32(d_sel[31:0]) : d_sel;
  end

  // Divider operand and partial-result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd       <= '0;
      sor       <= '0;
      rem       <= '0;
      quo       <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (accept) begin
      dvd       <= mag(a_in, div_neg_a, w_in);
      sor       <= mag(b_in, div_neg_b, w_in);
      rem       <= '0;
      quo       <= '0;
      quo_neg_q <= div_neg_a ^ div_neg_b;
      rem_neg_q <= div_neg_a;
    end else if (!mdu_i_flush && state == DIV) begin
      dvd <= dvd << 1;
      rem <= rem_next;
      quo <= quo_next;
    end
  end
`else
  assign short_op   = is_div_in;
  assign short_res  = '0;
  assign div_res    = '0;
  assign illegal_in = is_div_in;
`endif

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; flush wins over everything
  always_comb begin
    state_next = state;
    if (mdu_i_flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (mdu_i_valid) state_next = short_op ? DONE : (is_div_in ? DIV : MUL);
        MUL, DIV: if (last) state_next = DONE;
        DONE:     if (mdu_i_ready) state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    mdu_o_ready   = (state == IDLE);
    mdu_o_valid   = (state == DONE);
    mdu_o_illegal = (state == DONE) && illegal_q;
  end

  assign mdu_o_valE = val_e;

  // Operation latch, multiplier iteration and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      func_q    <= '0;
      w_q       <= 1'b0;
      mul_neg_q <= 1'b0;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      val_e     <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      func_q    <= mdu_i_func;
      w_q       <= w_in;
      mul_neg_q <= mul_neg_a ^ mul_neg_b;
      cnt       <= '0;
      mcand     <= {{XLEN{1'b0}}, mag(a_in, mul_neg_a, w_in)};
      mplier    <= mag(b_in, mul_neg_b, w_in);
      prod      <= '0;
      illegal_q <= illegal_in;
      if (short_op) val_e <= short_res;
    end else if (!mdu_i_flush && state == MUL) begin
      cnt    <= cnt + CW'(1);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      prod   <= prod_next;
      if (last) val_e <= mul_res;
    end else if (!mdu_i_flush && state == DIV) begin
      cnt <= cnt + CW'(1);
      if (last) val_e <= div_res;
    end
  end

endmodule

// File: tb/tb_execute_mdu.sv
// tb_execute_mdu: directed vectors for execute_mdu (XLEN=64) with hand-computed
// results; divider vectors are used when MDU_DIV_EN is defined, otherwise the
// illegal-function behaviour is exercised instead.
module tb_execute_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mdu_i_valid;
  logic        mdu_o_ready;
  logic [2:0]  mdu_i_func;
  logic        mdu_i_W_instr;
  logic [63:0] mdu_i_valA;
  logic [63:0] mdu_i_valB;
  logic        mdu_i_flush;
  logic        mdu_o_valid;
  logic        mdu_i_ready;
  logic [63:0] mdu_o_valE;
  logic        mdu_o_illegal;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_val = 64'd0;

  execute_mdu #(.XLEN(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mdu_i_valid  (mdu_i_valid),
    .mdu_o_ready  (mdu_o_ready),
    .mdu_i_func   (mdu_i_func),
    .mdu_i_W_instr(mdu_i_W_instr),
    .mdu_i_valA   (mdu_i_valA),
    .mdu_i_valB   (mdu_i_valB),
    .mdu_i_flush  (mdu_i_flush),
    .mdu_o_valid  (mdu_o_valid),
    .mdu_i_ready  (mdu_i_ready),
    .mdu_o_valE   (mdu_o_valE),
    .mdu_o_illegal(mdu_o_illegal)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Abort if the run ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
    int guard;
    guard = 0;
    while (!mdu_o_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("accept_ready", 64'(mdu_o_ready), 64'd1);
    mdu_i_func    = f;
    mdu_i_W_instr = w;
    mdu_i_valA    = a;
    mdu_i_valB    = b;
    mdu_i_valid   = 1'b1;
    @(posedge clk); #1;
    mdu_i_valid   = 1'b0;
    mdu_i_func    = ~f;
    mdu_i_W_instr = ~w;
    mdu_i_valA    = ~a;
    mdu_i_valB    = 64'd0;
  endtask

  task automatic waitResult(output int lat);
    lat = 1;
    while (!mdu_o_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_val, input int exp_lat, input logic exp_ill);
    int lat;
    applyStimulus(f, w, a, b);
    waitResult(lat);
    checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_val"}, mdu_o_valE, exp_val);
    checkOutput({tag, "_ill"}, 64'(mdu_o_illegal), 64'(exp_ill));
    mdu_i_ready = 1'b1;
    @(posedge clk); #1;
    mdu_i_ready = 1'b0;
    checkOutput({tag, "_rel"}, 64'(mdu_o_valid), 64'd0);
    last_val = exp_val;
  endtask

  // Main directed sequence
  initial begin
    int   lat;
    logic saw_valid;
    rst_n = 1'b0;
    mdu_i_valid = 1'b0;
    mdu_i_func = 3'd0;
    mdu_i_W_instr = 1'b0;
    mdu_i_valA = 64'd0;
    mdu_i_valB = 64'd0;
    mdu_i_flush = 1'b0;
    mdu_i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rst_ready", 64'(mdu_o_ready), 64'd1);
    checkOutput("rst_valid", 64'(mdu_o_valid), 64'd0);
    checkOutput("rst_valE", mdu_o_valE, 64'd0);
    checkOutput("rst_illegal", 64'(mdu_o_illegal), 64'd0);

    runOp("mul_7_m3", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1'b0);
    runOp("mulhu_max_2", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65, 1'b0);
    runOp("mulh_m2_3", 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
    runOp("mulhsu_m1_min", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
    runOp("mulh_m1_min", 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 65, 1'b0);
    runOp("mulw_7fff_2", 3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1'b0);

`ifdef MDU_DIV_EN
    runOp("div_100_0", 3'd4, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
    runOp("rem_100_0", 3'd6, 1'b0, 64'd100, 64'd0, 64'd100, 1, 1'b0);
    runOp("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 1'b0);
    runOp("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 1'b0);
    runOp("divuw_10_4", 3'd5, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd4, 64'd4, 33, 1'b0);
    runOp("rem_m7_2", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
    runOp("div_m7_2", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0);
    runOp("divu_100_7", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65, 1'b0);
    runOp("remu_100_7", 3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65, 1'b0);
    runOp("divw_m7_2", 3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b0);
    runOp("divuw_big_1", 3'd5, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1'b0);
    applyStimulus(3'd4, 1'b0, 64'd100, 64'd7);
`else
    runOp("divu_illegal", 3'd5, 1'b0, 64'd9, 64'd3, 64'd0, 1, 1'b1);
    runOp("rem_illegal", 3'd6, 1'b0, 64'd100, 64'd7, 64'd0, 1, 1'b1);
    runOp("mul_after_ill", 3'd0, 1'b0, 64'd6, 64'd9, 64'd54, 65, 1'b0);
    applyStimulus(3'd0, 1'b0, 64'd100, 64'd7);
`endif

    // Flush ten cycles into a long operation
    saw_valid = mdu_o_valid;
    repeat (9) begin
      @(posedge clk); #1;
      saw_valid = saw_valid | mdu_o_valid;
    end
    mdu_i_flush = 1'b1;
    @(posedge clk); #1;
    mdu_i_flush = 1'b0;
    checkOutput("flush_ready", 64'(mdu_o_ready), 64'd1);
    checkOutput("flush_valE_kept", mdu_o_valE, last_val);
    repeat (80) begin
      @(posedge clk); #1;
      saw_valid = saw_valid | mdu_o_valid;
    end
    checkOutput("flush_no_valid", 64'(saw_valid), 64'd0);
    runOp("mul_3_5", 3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 65, 1'b0);

    // Operation offered together with flush must be dropped
    mdu_i_func = 3'd0;
    mdu_i_W_instr = 1'b1;
    mdu_i_valA = 64'd2;
    mdu_i_valB = 64'd2;
    mdu_i_valid = 1'b1;
    mdu_i_flush = 1'b1;
    @(posedge clk); #1;
    mdu_i_valid = 1'b0;
    mdu_i_flush = 1'b0;
    checkOutput("flush_accept_ready", 64'(mdu_o_ready), 64'd1);

    // Consumer stalls five cycles in DONE, then a new op is offered in the handshake cycle
    applyStimulus(3'd0, 1'b1, 64'd6, 64'd7);
    waitResult(lat);
    checkOutput("hold_lat", 64'(lat), 64'd33);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", 64'(mdu_o_valid), 64'd1);
      checkOutput("hold_valE", mdu_o_valE, 64'd42);
      checkOutput("hold_ready", 64'(mdu_o_ready), 64'd0);
      @(posedge clk); #1;
    end
    mdu_i_ready = 1'b1;
    mdu_i_func = 3'd0;
    mdu_i_W_instr = 1'b0;
    mdu_i_valA = 64'd1;
    mdu_i_valB = 64'd1;
    mdu_i_valid = 1'b1;
    checkOutput("hs_ready_low", 64'(mdu_o_ready), 64'd0);
    @(posedge clk); #1;
    mdu_i_ready = 1'b0;
    mdu_i_valid = 1'b0;
    checkOutput("hs_ready_after", 64'(mdu_o_ready), 64'd1);
    checkOutput("hs_valid_after", 64'(mdu_o_valid), 64'd0);

    // Reset in the middle of an operation
    applyStimulus(3'd0, 1'b0, 64'd11, 64'd13);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("mrst_ready", 64'(mdu_o_ready), 64'd1);
    checkOutput("mrst_valid", 64'(mdu_o_valid), 64'd0);
    checkOutput("mrst_valE", mdu_o_valE, 64'd0);
    saw_valid = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      saw_valid = saw_valid | mdu_o_valid;
    end
    checkOutput("mrst_no_valid", 64'(saw_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_mdu.md
EXECUTE_MDU -- requirements
Module: execute_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width (32 or 64).
REQ-002 SHALL have ports, in order:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  synchronous active-low reset
- mdu_i_valid  input  1  operation offered
- mdu_o_ready  output  1  operation can be accepted
- mdu_i_func  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- mdu_i_W_instr  input  1  32-bit W variant
- mdu_i_valA  input  XLEN  operand A / dividend
- mdu_i_valB  input  XLEN  operand B / divisor
- mdu_i_flush  input  1  kill in-flight operation
- mdu_o_valid  output  1  result available
- mdu_i_ready  input  1  consumer takes result
- mdu_o_valE  output  XLEN  result
- mdu_o_illegal  output  1  function not supported in this build

Function
REQ-003 SHALL use four states: IDLE, MUL, DIV, DONE.
REQ-004 SHALL drive mdu_o_ready high only in IDLE; an operation is accepted on a clock edge where mdu_i_valid and mdu_o_ready are both high.
REQ-005 SHALL latch func, W flag and both operands on acceptance; later input changes have no effect on that operation.
REQ-006 SHALL set the iteration count N to 32 when W_instr is high, otherwise to XLEN; W is legal only when XLEN=64, and W with XLEN=32 behaves as non-W.
REQ-007 SHALL perform MUL-class operations in state MUL as a shift-add of 1 bit per cycle over N cycles, producing a 2N-bit product. Signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
REQ-008 SHALL perform DIV-class operations in state DIV as restoring division of magnitudes, 1 quotient bit per cycle over N cycles, then apply sign correction. Quotient sign is signA^signB; remainder takes the sign of the dividend.
REQ-009 SHALL enter DONE after the Nth iteration, so that mdu_o_valid rises exactly N+1 cycles after acceptance.
REQ-010 SHALL detect a zero divisor at acceptance and go directly to DONE (1-cycle latency), returning quotient all-ones and remainder equal to the dividend.
REQ-011 SHALL detect signed overflow (most-negative value / -1, DIV/REM only) at acceptance and go directly to DONE, returning quotient equal to the dividend and remainder 0.
REQ-012 SHALL select the result as follows: MUL gives the low N bits of the product; MULH* give the high N bits; DIV* give the quotient; REM* give the remainder. When W is set, the 32-bit result is sign-extended to XLEN, including DIVUW/REMUW.
REQ-013 SHALL hold mdu_o_valE and mdu_o_valid stable in DONE until mdu_i_ready is high, then return to IDLE on that edge.
REQ-014 SHALL accept no new operation in the cycle of a DONE handshake; mdu_o_ready rises the following cycle.
REQ-015 SHALL, when mdu_i_flush is high, go to IDLE on that edge from any state, discard any result, never assert mdu_o_valid for the killed operation, and not accept an operation offered in the same cycle.
REQ-016 SHALL keep mdu_o_valE at its last value outside DONE, with no X propagation.

Reset
REQ-017 SHALL, on a rising edge with rst_n low, enter IDLE and clear all registers: mdu_o_valid=0, mdu_o_valE=0, mdu_o_illegal=0, iteration counter=0.
REQ-018 SHALL treat reset mid-operation like a flush, with no result produced; mdu_o_ready=1 in the first cycle after reset is released.

Configuration
REQ-019 SHALL compile the divider in only when macro MDU_DIV_EN is defined.
REQ-020 SHALL, with MDU_DIV_EN defined, keep mdu_o_illegal at 0 at all times.
REQ-021 SHALL, without MDU_DIV_EN, infer no divider logic; func 4-7 go to DONE in 1 cycle with mdu_o_valE=0 and mdu_o_illegal=1 for the duration of DONE; MUL-class behaviour is unchanged.

Verification (XLEN=64, MDU_DIV_EN defined unless stated)
REQ-022 MUL, A=7, B=-3 -> valE=0xFFFF_FFFF_FFFF_FFEB, valid exactly 65 cycles after accept; MULHU, A=0xFFFF_FFFF_FFFF_FFFF, B=2 -> valE=1.
REQ-023 DIV 100/0 -> 0xFFFF_FFFF_FFFF_FFFF after 1 cycle; REM 100/0 -> 100; DIV 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000; REM of the same operands -> 0.
REQ-024 MULW 0x7FFF_FFFF×2 -> 0xFFFF_FFFF_FFFF_FFFE after 33 cycles; DIVUW A=0xFFFF_FFFF_0000_0010, B=4 -> 4; REM -7/2 -> -1.
REQ-025 Flush asserted 10 cycles into a DIV -> mdu_o_valid never rises, mdu_o_ready=1 next cycle, and a following MUL 3×5 -> 15.
REQ-026 mdu_i_ready held low 5 cycles in DONE -> valE/valid stable throughout, and mdu_o_ready stays low until the cycle after the handshake.
REQ-027 Without MDU_DIV_EN, DIVU 9/3 -> valE=0, illegal=1, 1-cycle latency.
